// File: rtl/jpeg_rle_symbolizer.sv
// Run-length symbolizer for the JPEG baseline encoder: zigzag coefficients in,
// (run, size, amplitude) symbols out, with DPCM on the DC coefficient.
module jpeg_rle_symbolizer #(
  parameter int COEF_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     dc_reset,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_run,
  output logic [3:0]               out_size,
  output logic [COEF_W-1:0]        out_amp,
  output logic                     out_dc,
  output logic                     out_last
);

  localparam int DW = COEF_W + 1;

  typedef enum logic {ACCEPT, ZRL} state_t;

  state_t                   state, state_nxt;
  logic [5:0]               idx, idx_nxt, run, run_nxt;
  logic signed [COEF_W-1:0] pred, pred_nxt, lat_coef, lat_coef_nxt;
  logic                     lat_last, lat_last_nxt;

  logic                     vld_p1, dc_p1, last_p1;
  logic [3:0]               run_p1, size_p1;
  logic [COEF_W-1:0]        amp_p1;

  logic                     load, ld_dc, ld_last;
  logic [3:0]               ld_run, ld_size;
  logic [COEF_W-1:0]        ld_amp;
  logic signed [DW-1:0]     sym_val;

  logic                     accept, adv;
  logic signed [COEF_W-1:0] pred_eff;
  logic signed [DW-1:0]     dc_diff, coef_ext, lat_ext;

  function automatic logic [3:0] calc_size(input logic signed [DW-1:0] v);
    logic [DW-1:0] mag;
    logic [3:0]    s;
    mag = (v < 0) ? -v : v;
    s = 4'd0;
    for (int i = 0; i < DW; i++)
      if (mag[i]) s = 4'(i + 1);
    return s;
  endfunction

  // Negative values carry v-1 so the leading amplitude bit is 0, as JPEG expects.
  function automatic logic [COEF_W-1:0] calc_amp(input logic signed [DW-1:0] v,
                                                 input logic [3:0] size);
    logic [DW-1:0] a, mask;
    a    = (v < 0) ? v - DW'(1) : v;
    mask = ~({DW{1'b1}} << size);
    a    = a & mask;
    return a[COEF_W-1:0];
  endfunction

  assign adv      = ~vld_p1 | out_ready;
  assign in_ready = ~rst & (state == ACCEPT) & adv;
  assign accept   = in_valid & in_ready;
  assign pred_eff = dc_reset ? '0 : pred;
  assign coef_ext = {in_coef[COEF_W-1], in_coef};
  assign lat_ext  = {lat_coef[COEF_W-1], lat_coef};
  assign dc_diff  = coef_ext - {pred_eff[COEF_W-1], pred_eff};

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    run_nxt      = run;
    pred_nxt     = pred;
    lat_coef_nxt = lat_coef;
    lat_last_nxt = lat_last;
    load         = 1'b0;
    ld_dc        = 1'b0;
    ld_last      = 1'b0;
    ld_run       = 4'd0;
    sym_val      = '0;
    if (dc_reset) pred_nxt = '0;
    if (accept) begin
      idx_nxt = idx + 6'd1;
      if (idx == 6'd0) begin
        load     = 1'b1;
        ld_dc    = 1'b1;
        sym_val  = dc_diff;
        pred_nxt = in_coef;
        run_nxt  = 6'd0;
      end else if (in_coef == '0) begin
        if (idx == 6'd63) begin
          load    = 1'b1;
          ld_last = 1'b1;
          run_nxt = 6'd0;
        end else begin
          run_nxt = run + 6'd1;
        end
      end else if (run < 6'd16) begin
        load    = 1'b1;
        ld_run  = run[3:0];
        sym_val = coef_ext;
        ld_last = (idx == 6'd63);
        run_nxt = 6'd0;
      end else begin
        // Park the coefficient and start draining the run as ZRL symbols.
        load         = 1'b1;
        ld_run       = 4'd15;
        run_nxt      = run - 6'd16;
        lat_coef_nxt = in_coef;
        lat_last_nxt = (idx == 6'd63);
        state_nxt    = ZRL;
      end
    end else if (state == ZRL && adv) begin
      load = 1'b1;
      if (run >= 6'd16) begin
        ld_run  = 4'd15;
        run_nxt = run - 6'd16;
      end else begin
        ld_run    = run[3:0];
        sym_val   = lat_ext;
        ld_last   = lat_last;
        run_nxt   = 6'd0;
        state_nxt = ACCEPT;
      end
    end
    ld_size = calc_size(sym_val);
    ld_amp  = calc_amp(sym_val, ld_size);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
      idx   <= 6'd0;
      run   <= 6'd0;
      pred  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      run   <= run_nxt;
      pred  <= pred_nxt;
    end
  end

  always_ff @(posedge clk) begin
    lat_coef <= lat_coef_nxt;
    lat_last <= lat_last_nxt;
  end

  // ---- p1: output symbol register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      run_p1  <= 4'd0;
      size_p1 <= 4'd0;
      amp_p1  <= '0;
      dc_p1   <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      run_p1  <= ld_run;
      size_p1 <= ld_size;
      amp_p1  <= ld_amp;
      dc_p1   <= ld_dc;
      last_p1 <= ld_last;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_run   = run_p1;
  assign out_size  = size_p1;
  assign out_amp   = amp_p1;
  assign out_dc    = dc_p1;
  assign out_last  = last_p1;

endmodule
